sp_packet_decoder: RTL and testbench
====================================

Name: sp_packet_decoder

Overview:
Receive-side service-protocol parser placed directly downstream of the SPI word receiver and upstream of the MIL transmit ring buffers. It consumes a stream of 16-bit SPI words and recognises packets addressed to either of two block addresses. It strips the header and escape words, pushes the payload words with command/data tags, and validates the 16-bit additive checksum. Packets for other addresses are skipped but length-tracked so that framing stays in sync.

Parameters:
ADDR0, 8'hAB, service address of channel 0 (addr_sel=0)
ADDR1, 8'hAC, service address of channel 1 (addr_sel=1)
ESC_CMD, 16'hFFA1, escape: next payload word is a MIL command word
ESC_DATA, 16'hFFA3, escape: next payload word is literal data
TIMEOUT, 16'd2000, idle clocks between words before an in-packet abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
in_data  in  16  SPI word
in_request  in  1  one-cycle strobe, in_data valid
out_data  out  16  payload word
out_push  out  1  one-cycle strobe, out_data valid
out_is_cmd  out  1  payload word was preceded by ESC_CMD
addr_sel  out  1  channel of the current packet, held from the header to the end of the packet
pkt_cmd  out  8  command byte of the current packet
pkt_start  out  1  pulse, header of an own packet accepted
pkt_ok  out  1  pulse, checksum matched (own packet)
pkt_err  out  1  pulse, checksum mismatch, bad escape or timeout (own packet)
busy  out  1  state != IDLE

Behaviour:
- Reset values: every output is 0 and the state is IDLE. Reset is asynchronous and may occur mid-packet: any partial packet is dropped and no pulse is emitted.
- Packet word order: ADDR word (addr in [15:8], [7:0] ignored), HDR word (size in [15:8] = payload word count including escape words, cmd in [7:0]), size payload words, CHECKSUM word, NUM word (ignored).
- Checksum: mod-2^16 sum of ADDR, HDR and all payload words, escape words included. The CHECKSUM and NUM words are excluded.
- All outputs are registered. A word accepted on cycle N produces its out_push or pulse on cycle N+1.
- States:
  - IDLE: on in_request, latch own = (addr==ADDR0 || addr==ADDR1) and addr_sel = (addr==ADDR1), then go to HDR.
  - HDR: latch size, cmd and the running sum. If own, pulse pkt_start. Go to PAYLOAD, or to CHECK if size==0.
  - PAYLOAD: decrement the remaining count on every word.
    - Word == ESC_CMD: set esc_cmd and go to ESCWAIT.
    - Word == ESC_DATA: go to ESCWAIT.
    - Any other word: push it (if own) with out_is_cmd=0.
    - After the last counted word, go to CHECK.
  - ESCWAIT: the next word is pushed (if own) with out_is_cmd=esc_cmd, never interpreted as an escape, and counts toward size. If the escape word was the last counted word, flag a bad escape and go to CHECK.
  - CHECK: compare the word against the sum. If own, pulse pkt_ok on match with no bad-escape flag, otherwise pulse pkt_err. Go to NUM.
  - NUM: consume one word, go to IDLE.
- Foreign packets walk the same states with out_push, pkt_* and out_is_cmd suppressed.
- Timeout: in any state other than IDLE, a counter clears on each in_request. When it reaches TIMEOUT, go to IDLE and pulse pkt_err if the packet is own.
- No backpressure: downstream must accept one push per cycle. Payload is forwarded before validation, so the consumer must commit on pkt_ok and roll back on pkt_err.
- Back-to-back words on consecutive cycles are supported. pkt_ok/pkt_err and the out_push for the last word never coincide.

Decomposition:
- Shared package: ESC_CMD/ESC_DATA defaults, the state enum, and the packet field helper functions (addr/size/cmd extraction).
- One natural sub-module: sp_checksum_acc (clear/add/compare, 16-bit), which the transmit-side encoder will reuse.

Test Plan:
1. Send AB00, 06A2, FFA1, 0001, 0002, AB45, FFA3, FFA1, 5BCF, 0000.
   - Pushes: 0001/cmd=1, 0002/0, AB45/0, FFA1/0.
   - pkt_start, then pkt_ok; addr_sel=0; pkt_cmd=A2.
2. Send AC00, 0AB2, ten 0000 words, B6B2, 0000.
   - Ten pushes of 0000/cmd=0, pkt_ok, addr_sel=1, pkt_cmd=B2.
3. Repeat test 1 with checksum 5BCE.
   - Same four pushes, then pkt_err and no pkt_ok.
4. Send a foreign packet CD00, 0201, 1111, 2222, 0000, 0000, immediately followed by the test-1 packet.
   - No output and no pulses for the first packet.
   - The second packet decodes exactly as in test 1.
5. Send AB00, 0101, FFA1, <chk>, 0000.
   - No push, and pkt_err from the bad escape.
6. Send AB00, 06A2, 0001, then stall for TIMEOUT+5 clocks.
   - One push and pkt_err at the timeout; busy=0 afterwards.
   - A new valid packet then decodes correctly.
   - Also assert rst mid-payload: outputs clear, no pulses, and the next packet decodes.

Source files
------------

// File: rtl/sp_packet_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sp_packet_decoder_pkg
// Description : Shared types, escape defaults and field helpers for the
//               service-protocol packet path.
// Revision    : 1.0 - initial release
// ============================================================================
package sp_packet_decoder_pkg;

    localparam logic [15:0] ESC_CMD_DEF  = 16'hFFA1;
    localparam logic [15:0] ESC_DATA_DEF = 16'hFFA3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_ESCWAIT = 3'd3,
        ST_CHECK   = 3'd4,
        ST_NUM     = 3'd5
    } state_t;

    function automatic logic [7:0] get_addr(input logic [15:0] w);
        return w[15:8];
    endfunction

    function automatic logic [7:0] get_size(input logic [15:0] w);
        return w[15:8];
    endfunction

    function automatic logic [7:0] get_cmd(input logic [15:0] w);
        return w[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_checksum_acc.sv
`default_nettype none
// ============================================================================
// Module      : sp_checksum_acc
// Description : 16-bit modular additive checksum accumulator with compare.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_checksum_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_add,
    input  logic [15:0] i_data,
    output logic        o_match
);

    logic [15:0] sum_q;
    logic [15:0] sum_d;

    // Load restarts the sum with the first word of a packet.
    always_comb begin
        sum_d = sum_q;
        if (i_load) begin
            sum_d = i_data;
        end else if (i_add) begin
            sum_d = sum_q + i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= 16'h0000;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign o_match = (sum_q == i_data);

endmodule
`default_nettype wire

// File: rtl/sp_packet_decoder.sv
`default_nettype none
// ============================================================================
// Module      : sp_packet_decoder
// Description : Service-protocol receive parser: header strip, escape
//               handling, payload tagging and checksum validation.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_packet_decoder
    import sp_packet_decoder_pkg::*;
#(
    parameter logic [7:0]  ADDR0    = 8'hAB,
    parameter logic [7:0]  ADDR1    = 8'hAC,
    parameter logic [15:0] ESC_CMD  = ESC_CMD_DEF,
    parameter logic [15:0] ESC_DATA = ESC_DATA_DEF,
    parameter logic [15:0] TIMEOUT  = 16'd2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_request,
    output logic [15:0] out_data,
    output logic        out_push,
    output logic        out_is_cmd,
    output logic        addr_sel,
    output logic [7:0]  pkt_cmd,
    output logic        pkt_start,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic        busy
);

    state_t      state_q, state_d;
    logic        own_q, own_d;
    logic        esc_cmd_q, esc_cmd_d;
    logic        bad_esc_q, bad_esc_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_push_q, out_push_d;
    logic        out_is_cmd_q, out_is_cmd_d;
    logic        addr_sel_q, addr_sel_d;
    logic [7:0]  pkt_cmd_q, pkt_cmd_d;
    logic        pkt_start_q, pkt_start_d;
    logic        pkt_ok_q, pkt_ok_d;
    logic        pkt_err_q, pkt_err_d;
    logic        busy_q, busy_d;

    logic        acc_load;
    logic        acc_add;
    logic        acc_match;
    logic        last_word;

    sp_checksum_acc u_checksum (
        .clk     (clk),
        .rst     (rst),
        .i_load  (acc_load),
        .i_add   (acc_add),
        .i_data  (in_data),
        .o_match (acc_match)
    );

    assign last_word = (remaining_q == 8'd1);

    always_comb begin
        state_d      = state_q;
        own_d        = own_q;
        esc_cmd_d    = esc_cmd_q;
        bad_esc_d    = bad_esc_q;
        remaining_d  = remaining_q;
        out_data_d   = out_data_q;
        out_push_d   = 1'b0;
        out_is_cmd_d = 1'b0;
        addr_sel_d   = addr_sel_q;
        pkt_cmd_d    = pkt_cmd_q;
        pkt_start_d  = 1'b0;
        pkt_ok_d     = 1'b0;
        pkt_err_d    = 1'b0;
        acc_load     = 1'b0;
        acc_add      = 1'b0;

        if (state_q == ST_IDLE || in_request) begin
            timer_d = 16'd0;
        end else begin
            timer_d = timer_q + 16'd1;
        end

        if (in_request) begin
            case (state_q)
                ST_IDLE: begin
                    own_d      = (get_addr(in_data) == ADDR0) || (get_addr(in_data) == ADDR1);
                    addr_sel_d = (get_addr(in_data) == ADDR1);
                    acc_load   = 1'b1;
                    state_d    = ST_HDR;
                end
                ST_HDR: begin
                    acc_add     = 1'b1;
                    remaining_d = get_size(in_data);
                    esc_cmd_d   = 1'b0;
                    bad_esc_d   = 1'b0;
                    if (own_q) begin
                        pkt_cmd_d   = get_cmd(in_data);
                        pkt_start_d = 1'b1;
                    end
                    state_d = (get_size(in_data) == 8'd0) ? ST_CHECK : ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    acc_add     = 1'b1;
                    remaining_d = remaining_q - 8'd1;
                    if (in_data == ESC_CMD || in_data == ESC_DATA) begin
                        esc_cmd_d = (in_data == ESC_CMD);
                        // An escape with nothing left to qualify is a framing error.
                        if (last_word) begin
                            bad_esc_d = 1'b1;
                            state_d   = ST_CHECK;
                        end else begin
                            state_d = ST_ESCWAIT;
                        end
                    end else begin
                        out_push_d = own_q;
                        out_data_d = own_q ? in_data : out_data_q;
                        state_d    = last_word ? ST_CHECK : ST_PAYLOAD;
                    end
                end
                ST_ESCWAIT: begin
                    acc_add      = 1'b1;
                    remaining_d  = remaining_q - 8'd1;
                    out_push_d   = own_q;
                    out_is_cmd_d = own_q & esc_cmd_q;
                    out_data_d   = own_q ? in_data : out_data_q;
                    state_d      = last_word ? ST_CHECK : ST_PAYLOAD;
                end
                ST_CHECK: begin
                    if (own_q) begin
                        pkt_ok_d  = acc_match & ~bad_esc_q;
                        pkt_err_d = ~(acc_match & ~bad_esc_q);
                    end
                    state_d = ST_NUM;
                end
                ST_NUM: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE && timer_d == TIMEOUT) begin
            state_d   = ST_IDLE;
            pkt_err_d = own_q;
            timer_d   = 16'd0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            own_q        <= 1'b0;
            esc_cmd_q    <= 1'b0;
            bad_esc_q    <= 1'b0;
            remaining_q  <= 8'd0;
            timer_q      <= 16'd0;
            out_data_q   <= 16'h0000;
            out_push_q   <= 1'b0;
            out_is_cmd_q <= 1'b0;
            addr_sel_q   <= 1'b0;
            pkt_cmd_q    <= 8'h00;
            pkt_start_q  <= 1'b0;
            pkt_ok_q     <= 1'b0;
            pkt_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            own_q        <= own_d;
            esc_cmd_q    <= esc_cmd_d;
            bad_esc_q    <= bad_esc_d;
            remaining_q  <= remaining_d;
            timer_q      <= timer_d;
            out_data_q   <= out_data_d;
            out_push_q   <= out_push_d;
            out_is_cmd_q <= out_is_cmd_d;
            addr_sel_q   <= addr_sel_d;
            pkt_cmd_q    <= pkt_cmd_d;
            pkt_start_q  <= pkt_start_d;
            pkt_ok_q     <= pkt_ok_d;
            pkt_err_q    <= pkt_err_d;
            busy_q       <= busy_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_push   = out_push_q;
    assign out_is_cmd = out_is_cmd_q;
    assign addr_sel   = addr_sel_q;
    assign pkt_cmd    = pkt_cmd_q;
    assign pkt_start  = pkt_start_q;
    assign pkt_ok     = pkt_ok_q;
    assign pkt_err    = pkt_err_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sp_packet_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_packet_decoder
// Description : Directed self-checking bench for sp_packet_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_packet_decoder;

    localparam int TMO = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = 16'h0000;
    logic        in_request = 1'b0;
    logic [15:0] out_data;
    logic        out_push;
    logic        out_is_cmd;
    logic        addr_sel;
    logic [7:0]  pkt_cmd;
    logic        pkt_start;
    logic        pkt_ok;
    logic        pkt_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    int n_ok = 0;
    int n_err = 0;
    int n_overlap = 0;
    logic [16:0] pq[$];
    logic [15:0] tx_q[$];

    sp_packet_decoder #(.TIMEOUT(16'(TMO))) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_request (in_request),
        .out_data   (out_data),
        .out_push   (out_push),
        .out_is_cmd (out_is_cmd),
        .addr_sel   (addr_sel),
        .pkt_cmd    (pkt_cmd),
        .pkt_start  (pkt_start),
        .pkt_ok     (pkt_ok),
        .pkt_err    (pkt_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Record pushes and pulses midway between active edges.
    always @(negedge clk) begin
        if (out_push) pq.push_back({out_is_cmd, out_data});
        if (pkt_start) n_start++;
        if (pkt_ok) n_ok++;
        if (pkt_err) n_err++;
        if (out_push && (pkt_ok || pkt_err)) n_overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_push(input string tag, input int idx, input logic [16:0] exp);
        logic [16:0] obs;
        obs = (idx < pq.size()) ? pq[idx] : 17'h1FFFF;
        chk(tag, {15'd0, obs}, {15'd0, exp});
    endtask

    task automatic clear_log();
        @(negedge clk);
        pq.delete();
        n_start = 0;
        n_ok = 0;
        n_err = 0;
    endtask

    // Drive the queued words on consecutive cycles.
    task automatic send_q();
        foreach (tx_q[i]) begin
            @(negedge clk);
            in_data    = tx_q[i];
            in_request = 1'b1;
        end
        @(negedge clk);
        in_request = 1'b0;
        in_data    = 16'h0000;
        tx_q.delete();
    endtask

    task automatic load_t1(input logic [15:0] chksum);
        tx_q.push_back(16'hAB00); tx_q.push_back(16'h06A2);
        tx_q.push_back(16'hFFA1); tx_q.push_back(16'h0001);
        tx_q.push_back(16'h0002); tx_q.push_back(16'hAB45);
        tx_q.push_back(16'hFFA3); tx_q.push_back(16'hFFA1);
        tx_q.push_back(chksum);   tx_q.push_back(16'h0000);
    endtask

    task automatic chk_t1_pushes(input string tag);
        chk({tag, "_npush"}, pq.size(), 4);
        chk_push({tag, "_p0"}, 0, {1'b1, 16'h0001});
        chk_push({tag, "_p1"}, 1, {1'b0, 16'h0002});
        chk_push({tag, "_p2"}, 2, {1'b0, 16'hAB45});
        chk_push({tag, "_p3"}, 3, {1'b0, 16'hFFA1});
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {out_data, out_push, out_is_cmd, addr_sel, pkt_cmd, pkt_start, pkt_ok, pkt_err}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Test 1: own packet on ADDR0 with escapes
        clear_log();
        load_t1(16'h5BCF);
        send_q();
        repeat (3) @(negedge clk);
        chk_t1_pushes("t1");
        chk("t1_start", n_start, 1);
        chk("t1_ok", n_ok, 1);
        chk("t1_err", n_err, 0);
        chk("t1_addr_sel", addr_sel, 0);
        chk("t1_cmd", pkt_cmd, 8'hA2);
        chk("t1_busy", busy, 0);

        // Test 2: ten zero words on ADDR1
        clear_log();
        tx_q.push_back(16'hAC00); tx_q.push_back(16'h0AB2);
        for (int i = 0; i < 10; i++) tx_q.push_back(16'h0000);
        tx_q.push_back(16'hB6B2); tx_q.push_back(16'h0000);
        send_q();
        repeat (3) @(negedge clk);
        chk("t2_npush", pq.size(), 10);
        chk_push("t2_p0", 0, 17'h00000);
        chk_push("t2_p9", 9, 17'h00000);
        chk("t2_ok", n_ok, 1);
        chk("t2_err", n_err, 0);
        chk("t2_addr_sel", addr_sel, 1);
        chk("t2_cmd", pkt_cmd, 8'hB2);

        // Test 3: checksum off by one
        clear_log();
        load_t1(16'h5BCE);
        send_q();
        repeat (3) @(negedge clk);
        chk_t1_pushes("t3");
        chk("t3_ok", n_ok, 0);
        chk("t3_err", n_err, 1);

        // Test 4: foreign packet followed back-to-back by own packet
        clear_log();
        tx_q.push_back(16'hCD00); tx_q.push_back(16'h0201);
        tx_q.push_back(16'h1111); tx_q.push_back(16'h2222);
        tx_q.push_back(16'h0000); tx_q.push_back(16'h0000);
        load_t1(16'h5BCF);
        send_q();
        repeat (3) @(negedge clk);
        chk_t1_pushes("t4");
        chk("t4_start", n_start, 1);
        chk("t4_ok", n_ok, 1);
        chk("t4_err", n_err, 0);
        chk("t4_cmd", pkt_cmd, 8'hA2);

        // Test 5: escape as last counted word
        clear_log();
        tx_q.push_back(16'hAB00); tx_q.push_back(16'h0101);
        tx_q.push_back(16'hFFA1); tx_q.push_back(16'hABA2);
        tx_q.push_back(16'h0000);
        send_q();
        repeat (3) @(negedge clk);
        chk("t5_npush", pq.size(), 0);
        chk("t5_ok", n_ok, 0);
        chk("t5_err", n_err, 1);
        chk("t5_busy", busy, 0);

        // Test 6: inter-word timeout
        clear_log();
        tx_q.push_back(16'hAB00); tx_q.push_back(16'h06A2); tx_q.push_back(16'h0001);
        send_q();
        repeat (TMO + 5) @(negedge clk);
        chk("t6_npush", pq.size(), 1);
        chk_push("t6_p0", 0, {1'b0, 16'h0001});
        chk("t6_ok", n_ok, 0);
        chk("t6_err", n_err, 1);
        chk("t6_busy", busy, 0);

        clear_log();
        load_t1(16'h5BCF);
        send_q();
        repeat (3) @(negedge clk);
        chk_t1_pushes("t6b");
        chk("t6b_ok", n_ok, 1);
        chk("t6b_err", n_err, 0);

        // Asynchronous reset mid-payload
        tx_q.push_back(16'hAB00); tx_q.push_back(16'h06A2);
        tx_q.push_back(16'h0001); tx_q.push_back(16'h0002);
        send_q();
        clear_log();
        rst = 1'b1;
        #2;
        chk("rstm_outs", {out_data, out_push, out_is_cmd, addr_sel, pkt_cmd, pkt_start, pkt_ok, pkt_err, busy}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstm_pulses", n_start + n_ok + n_err, 0);
        chk("rstm_busy", busy, 0);

        clear_log();
        load_t1(16'h5BCF);
        send_q();
        repeat (3) @(negedge clk);
        chk_t1_pushes("rstm_next");
        chk("rstm_next_ok", n_ok, 1);
        chk("rstm_next_err", n_err, 0);

        chk("no_overlap", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
